// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
package if_pkg;
  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESP,
    DROP_RESP
  } fetch_state_e;

  localparam int unsigned DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_INSTR     = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instr} entries; supports simultaneous push and pop when full.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [63:0]              push_data,
  input  logic                     pop,
  output logic [63:0]              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: single-outstanding memory requester feeding a prefetch
// queue, with a decode-facing output register, freeze hold and branch redirect.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_Addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        valid
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e state, state_nxt;
  logic [31:0]  fetch_pc;
  logic [31:0]  out_instr, out_pc;
  logic         out_valid;

  logic          take, bypass, fifo_push, fifo_pop;
  logic [63:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  // A response arriving with an empty queue and no freeze goes straight to the
  // output register so fetch-to-output latency stays at one cycle.
  assign take      = (state == WAIT_RESP) && imem_rvalid && !Branch_taken;
  assign bypass    = take && fifo_empty && !freeze;
  assign fifo_pop  = !freeze && !fifo_empty && !Branch_taken;
  assign fifo_push = take && !bypass && (!fifo_full || fifo_pop);

  assign imem_req  = (state == IDLE) && (fifo_count < CW'(DEPTH)) && !Branch_taken && !rst;
  assign imem_addr = fetch_pc;

  assign Instruction = out_instr;
  assign PC          = out_pc;
  assign valid       = out_valid;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (Branch_taken),
    .push      (fifo_push),
    .push_data ({fetch_pc + 32'd4, imem_rdata}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    if (Branch_taken) begin
      case (state)
        WAIT_RESP: state_nxt = imem_rvalid ? IDLE : DROP_RESP;
        DROP_RESP: state_nxt = imem_rvalid ? IDLE : DROP_RESP;
        default:   state_nxt = IDLE;
      endcase
    end else begin
      case (state)
        IDLE:      if (imem_req && imem_ready) state_nxt = WAIT_RESP;
        WAIT_RESP: if (imem_rvalid) state_nxt = IDLE;
        DROP_RESP: if (imem_rvalid) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      out_instr <= BUBBLE_INSTR;
      out_pc    <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (Branch_taken) begin
        fetch_pc  <= Branch_Addr;
        out_instr <= BUBBLE_INSTR;
        out_pc    <= '0;
        out_valid <= 1'b0;
      end else begin
        if (take) fetch_pc <= fetch_pc + 32'd4;
        if (!freeze) begin
          if (!fifo_empty) begin
            {out_pc, out_instr} <= fifo_head;
            out_valid           <= 1'b1;
          end else if (bypass) begin
            out_pc    <= fetch_pc + 32'd4;
            out_instr <= imem_rdata;
            out_valid <= 1'b1;
          end else begin
            out_instr <= BUBBLE_INSTR;
            out_pc    <= '0;
            out_valid <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Self-checking bench for if_prefetch_stage: vector table, directed corner cases
// and randomized traffic against a queue-based reference model.
module tb_if_prefetch_stage;
  import if_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, freeze, Branch_taken, imem_ready, imem_rvalid;
  logic [31:0] Branch_Addr, imem_rdata;
  logic        imem_req, valid;
  logic [31:0] imem_addr, Instruction, PC;

  always #5 clk = ~clk;

  if_prefetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .Branch_taken (Branch_taken),
    .Branch_Addr  (Branch_Addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .Instruction  (Instruction),
    .PC           (PC),
    .valid        (valid)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: fetch queue, next fetch address, outstanding/drop flags, output
  logic [63:0] m_q[$];
  logic [31:0] m_fpc = RESET_PC;
  logic        m_outst = 1'b0, m_drop = 1'b0, m_req = 1'b0;
  logic        m_v = 1'b0;
  logic [31:0] m_i = '0, m_pc = '0;

  // memory responder
  logic        r_pend = 1'b0;
  int unsigned r_cnt = 0, r_lat = 1, n_acc = 0;
  logic [31:0] r_addr = '0;

  logic        s_req;
  logic [31:0] s_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic br, input logic [31:0] ba,
                            input logic frz, input logic rdy, input logic rv,
                            input logic [31:0] rd);
    logic        have;
    logic [63:0] item;
    have = 1'b0;
    item = '0;
    if (r) begin
      m_q.delete();
      m_fpc = RESET_PC; m_outst = 1'b0; m_drop = 1'b0;
      m_v = 1'b0; m_i = '0; m_pc = '0;
    end else if (br) begin
      m_q.delete();
      m_v = 1'b0; m_i = '0; m_pc = '0;
      m_fpc = ba;
      if (m_outst) begin
        if (rv) begin m_outst = 1'b0; m_drop = 1'b0; end
        else m_drop = 1'b1;
      end
    end else begin
      if (m_outst && rv) begin
        m_outst = 1'b0;
        if (m_drop) m_drop = 1'b0;
        else begin
          have  = 1'b1;
          item  = {m_fpc + 32'd4, rd};
          m_fpc = m_fpc + 32'd4;
        end
      end
      if (m_req && rdy) m_outst = 1'b1;
      if (!frz) begin
        if (m_q.size() > 0) begin
          {m_pc, m_i} = m_q.pop_front();
          m_v = 1'b1;
          if (have) m_q.push_back(item);
        end else if (have) begin
          {m_pc, m_i} = item;
          m_v = 1'b1;
        end else begin
          m_v = 1'b0; m_i = '0; m_pc = '0;
        end
      end else if (have) begin
        m_q.push_back(item);
      end
    end
  endtask

  task automatic step(input logic r, input logic br, input logic [31:0] ba,
                      input logic frz, input logic rdy, input logic rv,
                      input logic [31:0] rd);
    logic acc;
    @(negedge clk);
    rst = r; Branch_taken = br; Branch_Addr = ba; freeze = frz;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    m_req = !r && !br && !m_outst && (m_q.size() < DEPTH);
    #1;
    s_req  = imem_req;
    s_addr = imem_addr;
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    if (m_req) chk("imem_addr", imem_addr, m_fpc);
    acc = imem_req && rdy;
    @(posedge clk);
    model_edge(r, br, ba, frz, rdy, rv, rd);
    if (rv) r_pend = 1'b0;
    if (r_pend && r_cnt > 0) r_cnt--;
    if (acc) begin
      r_pend = 1'b1; r_cnt = r_lat - 1; r_addr = s_addr; n_acc++;
    end
    #1;
    chk("valid", {31'b0, valid}, {31'b0, m_v});
    chk("Instruction", Instruction, m_i);
    chk("PC", PC, m_pc);
  endtask

  task automatic cyc(input logic r, input logic br, input logic [31:0] ba,
                     input logic frz, input logic rdy);
    logic rv;
    rv = r_pend && (r_cnt == 0);
    step(r, br, ba, frz, rdy, rv, rv ? r_addr : 32'hDEAD_BEEF);
  endtask

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] instr, pc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int unsigned a0;
    logic [31:0] first_addr;
    logic        seen;

    rst = 1'b1; freeze = 1'b0; Branch_taken = 1'b0; Branch_Addr = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // reset, then back-to-back fetch with data == address and one-cycle response
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h4};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 1'b1, 32'h4, 32'h8};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 32'h8, 32'hC};

    r_lat = 1;
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].rst, 1'b0, 32'h0, 1'b0, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
      chk("tbl_req", {31'b0, s_req}, {31'b0, tbl[i].req});
      if (tbl[i].req) chk("tbl_addr", s_addr, tbl[i].addr);
      chk("tbl_valid", {31'b0, valid}, {31'b0, tbl[i].v});
      chk("tbl_instr", Instruction, tbl[i].instr);
      chk("tbl_pc", PC, tbl[i].pc);
    end

    // memory not ready for five cycles: request held stable, accepted on the sixth
    first_addr = imem_addr;
    a0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("stall_req", {31'b0, s_req}, 32'h1);
      chk("stall_addr", s_addr, first_addr);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("stall_accept", n_acc - a0, 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // freeze for ten cycles: output held, queue fills with exactly four requests
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("pre_freeze_pc", PC, 32'h4);
    a0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk("freeze_hold_pc", PC, 32'h4);
    end
    chk("freeze_req_count", n_acc - a0, 32'd4);
    chk("freeze_full_req", {31'b0, s_req}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("release_pc", PC, 32'h8 + 32'(4 * i));
    end

    // fill the queue again, then branch together with freeze
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
    chk("brfrz_valid", {31'b0, valid}, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      if (s_req) begin
        seen = 1'b1;
        chk("brfrz_addr", s_addr, 32'h200);
      end
    end
    chk("brfrz_req_seen", {31'b0, seen}, 32'h1);

    // branch while waiting on a response: response dropped, refetch at target
    r_lat = 3;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      a0 = n_acc;
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      seen = (n_acc != a0);
    end
    chk("br_accept_seen", {31'b0, seen}, 32'h1);
    cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
    chk("br_bubble", {31'b0, valid}, 32'h0);
    r_lat = 1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      if (s_req) begin
        seen = 1'b1;
        chk("br_addr", s_addr, 32'h100);
      end
    end
    chk("br_req_seen", {31'b0, seen}, 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("br_first_pc", PC, 32'h104);

    // reset during an outstanding request; its response lands after reset
    r_lat = 2;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      a0 = n_acc;
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      seen = (n_acc != a0);
    end
    chk("rst_accept_seen", {31'b0, seen}, 32'h1);
    cyc(1'b1, 1'b1, 32'h300, 1'b1, 1'b1);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_stale_rv", {31'b0, r_pend && (r_cnt == 0)}, 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst_first_req", {31'b0, s_req}, 32'h1);
    chk("rst_first_addr", s_addr, RESET_PC);
    chk("rst_ignore_valid", {31'b0, valid}, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, br, frz, rdy, rv;
      r_lat = $urandom_range(1, 3);
      r   = ($urandom_range(199) == 0);
      br  = ($urandom_range(19) == 0);
      frz = ($urandom_range(2) == 0);
      rdy = ($urandom_range(3) != 0);
      rv  = r_pend && (r_cnt == 0);
      if (!r_pend && $urandom_range(7) == 0) rv = 1'b1;
      step(r, br, $urandom & 32'hFFFF_FFFC, frz, rdy, rv, rv && r_pend ? r_addr : $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/if_prefetch_stage.md
IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch-queue entries (power of two, 2..8).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 freeze  input  1  hazard stall from decode; holds the output register.
REQ-006 Branch_taken  input  1  redirect request from execute.
REQ-007 Branch_Addr  input  32  redirect target, word-aligned.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  32  request word address.
REQ-010 imem_ready  input  1  memory accepts request this cycle.
REQ-011 imem_rvalid  input  1  read data valid, one pulse per accepted request.
REQ-012 imem_rdata  input  32  read instruction word.
REQ-013 Instruction  output  32  instruction to decode; 32'h0 when bubble.
REQ-014 PC  output  32  fetch address of Instruction plus 4; 32'h0 when bubble.
REQ-015 valid  output  1  Instruction/PC hold a real instruction.

Function
REQ-016 SHALL keep fetch_pc, the address of the next request; it advances by 4 only when a response is pushed, wrapping modulo 2^32.
REQ-017 SHALL use FSM IDLE / WAIT_RESP / DROP_RESP with at most one outstanding request.
REQ-018 IDLE: imem_req=1 when queue count < DEPTH and no Branch_taken; imem_addr=fetch_pc; on imem_ready go WAIT_RESP.
REQ-019 imem_req/imem_addr SHALL stay stable while imem_req=1 and imem_ready=0, unless Branch_taken withdraws the request.
REQ-020 WAIT_RESP: imem_req=0; on imem_rvalid push {fetch_pc+4, imem_rdata}, fetch_pc+=4, go IDLE; next request issues no earlier than the following cycle.
REQ-021 DROP_RESP: imem_req=0; on imem_rvalid discard data, go IDLE; fetch_pc unchanged.
REQ-022 Output register SHALL load on each cycle where freeze=0: queue head (valid=1, pop) if queue non-empty, else bubble (valid=0, Instruction=0, PC=0).
REQ-023 freeze=1 and Branch_taken=0: output register and queue head unchanged; fetching continues until queue full.
REQ-024 Queue SHALL accept a push and a pop in the same cycle, including when full.
REQ-025 Branch_taken=1 SHALL take priority over freeze, over a push, and over a pop.
REQ-026 Branch_taken=1 SHALL: empty the queue, load a bubble into the output register, and set fetch_pc=Branch_Addr on the next edge.
REQ-027 Branch_taken=1 SHALL drive imem_req=0 that cycle.
REQ-028 Branch_taken=1 SHALL set the next state as follows: WAIT_RESP without imem_rvalid -> DROP_RESP; WAIT_RESP with imem_rvalid -> IDLE, data discarded; DROP_RESP without rvalid stays; otherwise IDLE.
REQ-029 Fetch-to-output latency SHALL be 1 cycle after imem_rvalid when the queue was empty and freeze=0.
REQ-030 imem_rvalid in IDLE SHALL be ignored.

Reset
REQ-031 On rst=1 SHALL set fetch_pc=RESET_PC, state=IDLE, queue empty, valid=0, Instruction=0, PC=0, imem_req=0 that cycle.
REQ-032 rst SHALL override Branch_taken and freeze.
REQ-033 An in-flight response arriving in the cycle after reset SHALL be ignored.

Structure
REQ-034 Shared package if_pkg SHALL hold the state enum, default DEPTH, RESET_PC and the BUBBLE_INSTR constant 32'h0.
REQ-035 Queue SHALL be sub-module fetch_fifo: synchronous flush, push, pop, count, full and empty outputs, each entry 64 bits {pc, instr}.
REQ-036 FSM, fetch_pc and output register SHALL live in if_prefetch_stage.

Verification
REQ-037 Reset, imem_ready=1, rvalid one cycle after accept, data=addr -> requests at 0,4,8,...; first valid output Instruction=0, PC=4.
REQ-038 freeze=1 for 10 cycles -> output held; exactly 4 requests issued, then imem_req=0 while full; release -> outputs in order, no loss or duplication.
REQ-039 Branch_taken=1 with Branch_Addr=32'h100 while a request is in WAIT_RESP -> next rvalid dropped; next request addr=32'h100; output bubble, then PC=32'h104.
REQ-040 Branch_taken and freeze both 1 with a full queue -> queue emptied; output bubble; fetch_pc=Branch_Addr.
REQ-041 imem_ready held 0 for 5 cycles -> imem_req and imem_addr stable throughout; accept on cycle 6.
REQ-042 rst asserted while in WAIT_RESP, with rvalid the next cycle -> all outputs 0, rvalid ignored, first request addr=RESET_PC.
